// File: rtl/pkt_mem_pkg.sv
// Shared constants, host-side state encoding and width check for the packet memory.
package pkt_mem_pkg;

   localparam int unsigned PKT_MEM_DATA_W      = 64;
   localparam int unsigned PKT_MEM_ADDR_W      = 32;
   localparam int unsigned PKT_MEM_DEPTH_BYTES = 4096;
   localparam int unsigned BANKS               = 8;
   localparam int unsigned LANE_W              = 3;
   localparam int unsigned WIDTH_MAX           = 8;

   typedef enum logic {
      H_IDLE = 1'b0,
      H_PEND = 1'b1
   } host_state_e;

   // A pipeline access is legal for 1..WIDTH_MAX bytes.
   function automatic logic width_legal(input logic [3:0] w);
      return (w != 4'd0) && (w <= 4'(WIDTH_MAX));
   endfunction

endpackage

// File: rtl/pkt_mem_byte_bank.sv
// One byte lane of the packet memory: 1 write port, 1 registered read-first read port.
module pkt_mem_byte_bank #(
   parameter int unsigned ROWS  = 512,
   parameter int unsigned ROW_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [ROW_W-1:0] waddr,
   input  logic [7:0]       wdata,
   input  logic             re,
   input  logic [ROW_W-1:0] raddr,
   output logic [7:0]       q
);

   logic [7:0] mem [ROWS];

   // Array write; contents are not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read returns the pre-write value on a same-row collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    q <= 8'h00;
      else if (re) q <= mem[raddr];
   end

endmodule

// File: rtl/pkt_mem.sv
// Byte-addressed packet/table memory: pipeline port of 1..8 bytes at any alignment plus a
// byte-wide host port that yields to pipeline writes on a bank conflict.
module pkt_mem
   import pkt_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = PKT_MEM_DATA_W,
   parameter int unsigned ADDR_W      = PKT_MEM_ADDR_W,
   parameter int unsigned DEPTH_BYTES = PKT_MEM_DEPTH_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [3:0]        mem_width_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [7:0]        host_data_i,
   output logic              host_ready_o,
   output logic              err_o
);

   localparam int unsigned EFF_W = $clog2(DEPTH_BYTES);
   localparam int unsigned ROWS  = DEPTH_BYTES / BANKS;
   localparam int unsigned ROW_W = EFF_W - LANE_W;

   logic [EFF_W-1:0]  a_c;
   logic              legal_c;
   logic              rd_issue_c;
   logic              wr_issue_c;
   logic              unused_c;

   logic [BANKS-1:0]  p_we;
   logic [LANE_W-1:0] p_k     [BANKS];
   logic [ROW_W-1:0]  p_row   [BANKS];
   logic [7:0]        p_wdata [BANKS];
   logic [7:0]        bank_q  [BANKS];

   host_state_e       state;
   host_state_e       state_next;
   logic              h_wr_c;
   logic              capture_c;
   logic [LANE_W-1:0] h_bank_c;
   logic [ROW_W-1:0]  h_row_c;
   logic [7:0]        h_data_c;
   logic [EFF_W-1:0]  pend_addr;
   logic [7:0]        pend_data;

   logic [3:0]        rd_w;
   logic [LANE_W-1:0] rd_off;

   assign a_c        = mem_addr_i[EFF_W-1:0];
   assign legal_c    = width_legal(mem_width_i);
   assign rd_issue_c = mem_ce_i && !mem_we_i && legal_c;
   assign wr_issue_c = mem_ce_i &&  mem_we_i && legal_c;
   assign unused_c   = ^{mem_addr_i[ADDR_W-1:EFF_W], host_addr_i[ADDR_W-1:EFF_W]};

   // Per bank: which field byte k lands here, its row (wrapping at the top), enable and write byte.
   always_comb begin
      for (int b = 0; b < BANKS; b++) begin
         p_k[b]     = LANE_W'(b) - a_c[LANE_W-1:0];
         p_we[b]    = wr_issue_c && ({1'b0, p_k[b]} < mem_width_i);
         p_row[b]   = ROW_W'((a_c + EFF_W'(p_k[b])) >> LANE_W);
         p_wdata[b] = mem_data_i[{LANE_W'(mem_width_i - 4'd1 - {1'b0, p_k[b]}), 3'b000} +: 8];
      end
   end

   // Host FSM next state and host write-port request.
   always_comb begin
      state_next = state;
      h_wr_c     = 1'b0;
      capture_c  = 1'b0;
      h_bank_c   = host_addr_i[LANE_W-1:0];
      h_row_c    = host_addr_i[EFF_W-1:LANE_W];
      h_data_c   = host_data_i;
      case (state)
         H_IDLE: begin
            if (host_we_i) begin
               if (p_we[host_addr_i[LANE_W-1:0]]) begin
                  capture_c  = 1'b1;
                  state_next = H_PEND;
               end else begin
                  h_wr_c = 1'b1;
               end
            end
         end
         H_PEND: begin
            h_bank_c = pend_addr[LANE_W-1:0];
            h_row_c  = pend_addr[EFF_W-1:LANE_W];
            h_data_c = pend_data;
            if (!p_we[pend_addr[LANE_W-1:0]]) begin
               h_wr_c     = 1'b1;
               state_next = H_IDLE;
            end
         end
         default: state_next = H_IDLE;
      endcase
   end

   // Host state, ready flag and the pending byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= H_IDLE;
         host_ready_o <= 1'b1;
         pend_addr    <= '0;
         pend_data    <= 8'h00;
      end else begin
         state        <= state_next;
         host_ready_o <= (state_next == H_IDLE);
         if (capture_c) begin
            pend_addr <= host_addr_i[EFF_W-1:0];
            pend_data <= host_data_i;
         end
      end
   end

   // Read alignment for the output steering, and the sticky illegal-width flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_w   <= 4'd0;
         rd_off <= '0;
         err_o  <= 1'b0;
      end else if (mem_ce_i) begin
         if (!legal_c) begin
            err_o <= 1'b1;
            rd_w  <= 4'd0;
         end else if (!mem_we_i) begin
            rd_w   <= mem_width_i;
            rd_off <= a_c[LANE_W-1:0];
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic             bank_we;
      logic [ROW_W-1:0] bank_waddr;
      logic [7:0]       bank_wdata;

      // Pipeline write owns the bank write port; the host uses it only when free.
      always_comb begin
         bank_we    = p_we[b] || (h_wr_c && (h_bank_c == LANE_W'(b)));
         bank_waddr = p_we[b] ? p_row[b]   : h_row_c;
         bank_wdata = p_we[b] ? p_wdata[b] : h_data_c;
      end

      pkt_mem_byte_bank #(
         .ROWS  (ROWS),
         .ROW_W (ROW_W)
      ) u_bank (
         .clk   (clk),
         .rst   (rst),
         .we    (bank_we),
         .waddr (bank_waddr),
         .wdata (bank_wdata),
         .re    (rd_issue_c),
         .raddr (p_row[b]),
         .q     (bank_q[b])
      );
   end

   // Right-justify the registered bank bytes, big-endian; only flops feed this steering.
   always_comb begin
      mem_data_o = '0;
      for (int j = 0; j < BANKS; j++) begin
         if (4'(j) < rd_w) begin
            mem_data_o[8*j +: 8] = bank_q[rd_off + LANE_W'(rd_w - 4'd1 - 4'(j))];
         end
      end
   end

endmodule

// File: tb/tb_pkt_mem.sv
// Directed self-checking bench for pkt_mem.
module tb_pkt_mem;

   localparam int unsigned DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [3:0]  mem_width_i;
   logic [63:0] mem_data_i;
   logic [63:0] mem_data_o;
   logic        host_we_i;
   logic [31:0] host_addr_i;
   logic [7:0]  host_data_i;
   logic        host_ready_o;
   logic        err_o;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pkt_mem u_dut (
      .clk          (clk),
      .rst          (rst),
      .mem_ce_i     (mem_ce_i),
      .mem_we_i     (mem_we_i),
      .mem_addr_i   (mem_addr_i),
      .mem_width_i  (mem_width_i),
      .mem_data_i   (mem_data_i),
      .mem_data_o   (mem_data_o),
      .host_we_i    (host_we_i),
      .host_addr_i  (host_addr_i),
      .host_data_i  (host_data_i),
      .host_ready_o (host_ready_o),
      .err_o        (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One pipeline access: driven at a falling edge, sampled by the next rising edge.
   task automatic pipe(input logic we, input logic [31:0] addr, input logic [3:0] w,
                       input logic [63:0] data);
      mem_ce_i    = 1'b1;
      mem_we_i    = we;
      mem_addr_i  = addr;
      mem_width_i = w;
      mem_data_i  = data;
      @(posedge clk);
      @(negedge clk);
      mem_ce_i = 1'b0;
      mem_we_i = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [3:0] w,
                     input logic [63:0] exp);
      pipe(1'b0, addr, w, 64'h0);
      chk(tag, mem_data_o, exp);
   endtask

   initial begin
      rst         = 1'b0;
      mem_ce_i    = 1'b0;
      mem_we_i    = 1'b0;
      mem_addr_i  = '0;
      mem_width_i = '0;
      mem_data_i  = '0;
      host_we_i   = 1'b0;
      host_addr_i = '0;
      host_data_i = '0;
      repeat (2) @(negedge clk);
      chk("reset_data",  mem_data_o, 64'h0);
      chk("reset_ready", 64'(host_ready_o), 64'h1);
      chk("reset_err",   64'(err_o), 64'h0);
      rst = 1'b1;
      @(negedge clk);

      // Aligned write/read, then a write leaves the read data held.
      pipe(1'b1, 32'h10, 4'd4, 64'hDEAD_BEEF);
      rd("aligned_w4", 32'h10, 4'd4, 64'h0000_0000_DEAD_BEEF);
      pipe(1'b1, 32'h50, 4'd2, 64'h1234);
      chk("hold_after_write", mem_data_o, 64'h0000_0000_DEAD_BEEF);

      // Unaligned 8-byte write and sub-reads.
      pipe(1'b1, 32'h0D, 4'd8, 64'h0102_0304_0506_0708);
      rd("unaligned_0f_w2", 32'h0F, 4'd2, 64'h0304);
      rd("unaligned_0d_w1", 32'h0D, 4'd1, 64'h01);
      rd("unaligned_10_w4", 32'h10, 4'd4, 64'h0405_0607);

      // Wrap across the top of memory; high address bits alias.
      pipe(1'b1, 32'(DEPTH - 2), 4'd4, 64'hAABB_CCDD);
      rd("wrap_low",   32'h0, 4'd2, 64'hCCDD);
      rd("wrap_high",  32'(DEPTH - 2), 4'd2, 64'hAABB);
      rd("wrap_alias", 32'(2 * DEPTH - 2), 4'd4, 64'hAABB_CCDD);

      // Bank conflict: pipeline write wins, host byte retires one cycle later.
      host_we_i   = 1'b1;
      host_addr_i = 32'h08;
      host_data_i = 8'h55;
      pipe(1'b1, 32'h10, 4'd1, 64'h77);
      chk("conflict_ready_low", 64'(host_ready_o), 64'h0);
      @(posedge clk);
      @(negedge clk);
      chk("conflict_ready_back", 64'(host_ready_o), 64'h1);
      host_we_i = 1'b0;
      rd("conflict_host_byte", 32'h08, 4'd1, 64'h55);
      rd("conflict_pipe_byte", 32'h10, 4'd1, 64'h77);

      // Plain host write.
      host_we_i   = 1'b1;
      host_addr_i = 32'h20;
      host_data_i = 8'h66;
      @(posedge clk);
      @(negedge clk);
      host_we_i = 1'b0;
      chk("host_plain_ready", 64'(host_ready_o), 64'h1);

      // Host write and pipeline read of the same byte: read returns the old value.
      host_we_i   = 1'b1;
      host_data_i = 8'h99;
      rd("read_first_old", 32'h20, 4'd1, 64'h66);
      host_we_i = 1'b0;
      rd("read_first_new", 32'h20, 4'd1, 64'h99);

      // Host and pipeline writes to different banks proceed together.
      host_we_i   = 1'b1;
      host_addr_i = 32'h21;
      host_data_i = 8'h3C;
      pipe(1'b1, 32'h28, 4'd1, 64'hC3);
      host_we_i = 1'b0;
      chk("diff_bank_ready", 64'(host_ready_o), 64'h1);
      rd("diff_bank_host", 32'h21, 4'd1, 64'h3C);
      rd("diff_bank_pipe", 32'h28, 4'd1, 64'hC3);

      // Illegal widths: zeroed data, sticky error, no RAM access.
      pipe(1'b0, 32'h10, 4'd0, 64'h0);
      chk("illegal_data", mem_data_o, 64'h0);
      chk("illegal_err",  64'(err_o), 64'h1);
      rd("legal_after_illegal", 32'h10, 4'd1, 64'h77);
      chk("err_sticky", 64'(err_o), 64'h1);
      pipe(1'b1, 32'h10, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF);
      rd("illegal_no_write", 32'h10, 4'd1, 64'h77);

      // Reset with a pending host byte and a held read result.
      pipe(1'b1, 32'h30, 4'd1, 64'h5A);
      rd("pre_reset_read", 32'h10, 4'd1, 64'h77);
      host_we_i   = 1'b1;
      host_addr_i = 32'h30;
      host_data_i = 8'hAB;
      pipe(1'b1, 32'h38, 4'd1, 64'h11);
      chk("pend_ready_low",   64'(host_ready_o), 64'h0);
      chk("pend_read_held",   mem_data_o, 64'h77);
      pipe(1'b1, 32'h40, 4'd1, 64'h22);
      chk("pend_still_low",   64'(host_ready_o), 64'h0);
      rst       = 1'b0;
      host_we_i = 1'b0;
      #1;
      chk("midreset_data",  mem_data_o, 64'h0);
      chk("midreset_ready", 64'(host_ready_o), 64'h1);
      chk("midreset_err",   64'(err_o), 64'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rd("dropped_host_byte", 32'h30, 4'd1, 64'h5A);
      rd("pend_pipe_38",      32'h38, 4'd1, 64'h11);
      rd("pend_pipe_40",      32'h40, 4'd1, 64'h22);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
